// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one external ALU between two requesters.
// Each operation runs IDLE (accept) -> EXEC (ALU evaluates) -> RESP (held until the owner accepts).
module alu_arbiter #(
  parameter int XLEN = 64,
  parameter int SELW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [SELW-1:0] req_sel0,
  input  logic [SELW-1:0] req_sel1,
  input  logic [XLEN-1:0] req_a0,
  input  logic [XLEN-1:0] req_a1,
  input  logic [XLEN-1:0] req_b0,
  input  logic [XLEN-1:0] req_b1,
  input  logic            req_sub_sra0,
  input  logic            req_sub_sra1,
  output logic [1:0]      resp_valid,
  input  logic [1:0]      resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic [4:0]      resp_flags,
  output logic [SELW-1:0] alu_sel,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic            alu_sub_sra,
  input  logic [XLEN-1:0] alu_result,
  input  logic [4:0]      alu_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            sub_sra_q, sub_sra_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      flags_q, flags_d;
  logic [1:0]      grant;
  logic            accept;

  // A lone requester always wins; on contention rr_ptr names the preferred one.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      assign grant[gi] = req_valid[gi] & (~req_valid[1-gi] | (rr_ptr_q == 1'(gi)));
    end
  endgenerate

  assign accept = (state_q == IDLE) & (|grant);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|grant) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; req_ready is also masked while reset is held
  always_comb begin
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    if (state_q == IDLE && !rst) req_ready = grant;
    if (state_q == RESP) resp_valid[owner_q] = 1'b1;
  end

  always_comb begin
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    sel_d     = sel_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_sra_d = sub_sra_q;
    result_d  = result_q;
    flags_d   = flags_q;
    if (accept) begin
      owner_d   = grant[1];
      rr_ptr_d  = ~grant[1];
      sel_d     = grant[1] ? req_sel1     : req_sel0;
      a_d       = grant[1] ? req_a1       : req_a0;
      b_d       = grant[1] ? req_b1       : req_b0;
      sub_sra_d = grant[1] ? req_sub_sra1 : req_sub_sra0;
    end
    if (state_q == EXEC) begin
      result_d = alu_result;
      flags_d  = alu_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q   <= 1'b0;
      rr_ptr_q  <= 1'b0;
      sel_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sub_sra_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      sel_q     <= sel_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sub_sra_q <= sub_sra_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  assign alu_sel     = sel_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_sub_sra = sub_sra_q;
  assign resp_result = result_q;
  assign resp_flags  = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small stand-in ALU (000 add/sub, 100 xor, else or).
// Inputs are driven at the falling edge; outputs are sampled 1 time unit later.
module tb_alu_arbiter;
  localparam int XLEN = 64;
  localparam int SELW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_ready, resp_valid, resp_ready;
  logic [SELW-1:0] req_sel0, req_sel1, alu_sel;
  logic [XLEN-1:0] req_a0, req_a1, req_b0, req_b1;
  logic            req_sub_sra0, req_sub_sra1, alu_sub_sra;
  logic [XLEN-1:0] resp_result, alu_a, alu_b, alu_result;
  logic [4:0]      resp_flags, alu_flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(XLEN), .SELW(SELW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel0(req_sel0), .req_sel1(req_sel1),
    .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1),
    .req_sub_sra0(req_sub_sra0), .req_sub_sra1(req_sub_sra1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_sub_sra(alu_sub_sra),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  // Stand-in ALU; flags = {cout, zero, overflow, smaller, equal}
  logic [XLEN-1:0] eff_b;
  logic [XLEN:0]   sum;
  logic            cout, ovf;
  always_comb begin
    eff_b      = alu_sub_sra ? ~alu_b : alu_b;
    sum        = {1'b0, alu_a} + {1'b0, eff_b} + {{XLEN{1'b0}}, alu_sub_sra};
    alu_result = '0;
    cout       = 1'b0;
    ovf        = 1'b0;
    case (alu_sel)
      3'b000: begin
        alu_result = sum[XLEN-1:0];
        cout       = sum[XLEN];
        ovf        = (alu_a[XLEN-1] == eff_b[XLEN-1]) && (alu_result[XLEN-1] != alu_a[XLEN-1]);
      end
      3'b100:  alu_result = alu_a ^ alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
    alu_flags = {cout, (alu_result == '0), ovf, ($signed(alu_a) < $signed(alu_b)), (alu_a == alu_b)};
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; resp_ready = 2'b00;
    req_sel0 = '0; req_sel1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    req_sub_sra0 = 1'b0; req_sub_sra1 = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 00", resp_valid); end
    n_checks++; if (resp_result !== 64'd0 || resp_flags !== 5'd0) begin n_fail++; $display("FAIL reset_resp_data: got %h/%b expected 0/00000", resp_result, resp_flags); end
    n_checks++; if (alu_a !== 64'd0 || alu_b !== 64'd0) begin n_fail++; $display("FAIL reset_alu_ops: got %h/%h expected 0/0", alu_a, alu_b); end
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    $display("reset done");
  endtask

  task automatic test_basic();
    apply_reset();
    req_valid = 2'b01; req_sel0 = 3'b000; req_a0 = 64'd5; req_b0 = 64'd3; req_sub_sra0 = 1'b1; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL basic_grant: got %b expected 01", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    n_checks++; if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin n_fail++; $display("FAIL basic_exec_hs: got ready %b valid %b expected 00/00", req_ready, resp_valid); end
    n_checks++; if (alu_a !== 64'd5 || alu_b !== 64'd3 || alu_sub_sra !== 1'b1 || alu_sel !== 3'b000) begin n_fail++; $display("FAIL basic_alu_drive: got a=%0d b=%0d sub=%b sel=%b expected 5/3/1/000", alu_a, alu_b, alu_sub_sra, alu_sel); end
    @(negedge clk); #1;
    n_checks++; if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL basic_resp_valid: got %b expected 01", resp_valid); end
    n_checks++; if (resp_result !== 64'd2) begin n_fail++; $display("FAIL basic_result: got %0d expected 2", resp_result); end
    n_checks++; if (resp_flags !== 5'b10000) begin n_fail++; $display("FAIL basic_flags: got %b expected 10000", resp_flags); end
    $display("txn basic: req0 5-3 -> %0d flags %b", resp_result, resp_flags);
    resp_ready = 2'b01;
    @(negedge clk); resp_ready = 2'b00; #1;
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL basic_resp_clear: got %b expected 00", resp_valid); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    req_sel0 = 3'b000; req_a0 = 64'd10;  req_b0 = 64'd4; req_sub_sra0 = 1'b0;
    req_sel1 = 3'b000; req_a1 = 64'd100; req_b1 = 64'd1; req_sub_sra1 = 1'b1;
    req_valid = 2'b11; resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [1:0]      exp_g;
      logic [XLEN-1:0] exp_r;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (k % 2 == 0) ? 64'd14 : 64'd99;
      #1;
      n_checks++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, exp_g); end
      @(negedge clk); #1;
      n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL rr_exec_valid[%0d]: got %b expected 00", k, resp_valid); end
      @(negedge clk); #1;
      n_checks++; if (resp_valid !== exp_g) begin n_fail++; $display("FAIL rr_resp_valid[%0d]: got %b expected %b", k, resp_valid, exp_g); end
      n_checks++; if (resp_result !== exp_r) begin n_fail++; $display("FAIL rr_result[%0d]: got %0d expected %0d", k, resp_result, exp_r); end
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rr_resp_ready[%0d]: got %b expected 00", k, req_ready); end
      $display("txn rr[%0d]: owner %b result %0d", k, resp_valid, resp_result);
      @(negedge clk);
    end
    req_valid = 2'b00; resp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_valid = 2'b01; req_sel0 = 3'b000; req_a0 = 64'd20; req_b0 = 64'd22; req_sub_sra0 = 1'b1; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_grant: got %b expected 01", req_ready); end
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (resp_valid !== 2'b01 || req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_hold_hs[%0d]: got valid %b ready %b expected 01/00", k, resp_valid, req_ready); end
      n_checks++; if (resp_result !== 64'hFFFF_FFFF_FFFF_FFFE || resp_flags !== 5'b00010) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %h/%b expected fffffffffffffffe/00010", k, resp_result, resp_flags); end
      req_a0 = 64'(k + 40);
      @(negedge clk);
    end
    req_sel0 = 3'b000; req_a0 = 64'd1; req_b0 = 64'd1; req_sub_sra0 = 1'b0; resp_ready = 2'b01; #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_no_accept_on_resp: got %b expected 00", req_ready); end
    $display("txn bp: req0 20-22 -> %h flags %b", resp_result, resp_flags);
    @(negedge clk); resp_ready = 2'b00; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_next_accept: got %b expected 01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    n_checks++; if (resp_result !== 64'd2) begin n_fail++; $display("FAIL bp_next_result: got %0d expected 2", resp_result); end
    resp_ready = 2'b01;
    @(negedge clk); resp_ready = 2'b00;
  endtask

  task automatic test_operand_hold();
    apply_reset();
    req_valid = 2'b01; req_sel0 = 3'b100; req_a0 = 64'd7; req_b0 = 64'd7; req_sub_sra0 = 1'b0;
    @(negedge clk); req_a0 = 64'd9; req_valid = 2'b00; #1;
    n_checks++; if (alu_a !== 64'd7) begin n_fail++; $display("FAIL hold_alu_a: got %0d expected 7", alu_a); end
    @(negedge clk); #1;
    n_checks++; if (resp_result !== 64'd0) begin n_fail++; $display("FAIL hold_result: got %0d expected 0", resp_result); end
    n_checks++; if (resp_flags[3] !== 1'b1 || resp_flags !== 5'b01001) begin n_fail++; $display("FAIL hold_flags: got %b expected 01001", resp_flags); end
    $display("txn hold: req0 7^7 -> %0d flags %b", resp_result, resp_flags);
    resp_ready = 2'b01;
    @(negedge clk); resp_ready = 2'b00;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    req_valid = 2'b01; req_sel0 = 3'b000; req_a0 = 64'd11; req_b0 = 64'd22; req_sub_sra0 = 1'b0;
    @(negedge clk); req_valid = 2'b00; rst = 1'b1; #1;
    n_checks++; if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_exec: got valid %b ready %b expected 00/00", resp_valid, req_ready); end
    @(negedge clk); rst = 1'b0; req_valid = 2'b11; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_exec_rrptr: got %b expected 01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    n_checks++; if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL rst_pre_resp: got %b expected 01", resp_valid); end
    rst = 1'b1; #1;
    n_checks++; if (resp_valid !== 2'b00 || resp_result !== 64'd0) begin n_fail++; $display("FAIL rst_resp: got valid %b result %0d expected 00/0", resp_valid, resp_result); end
    @(negedge clk); rst = 1'b0; req_valid = 2'b11; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_resp_rrptr: got %b expected 01", req_ready); end
    $display("txn rst: in-flight operations discarded");
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); resp_ready = 2'b11;
    @(negedge clk); resp_ready = 2'b00;
  endtask

  task automatic test_nonowner_ready();
    apply_reset();
    req_valid = 2'b10; req_sel1 = 3'b000; req_a1 = 64'd50; req_b1 = 64'd8; req_sub_sra1 = 1'b1;
    @(negedge clk); req_valid = 2'b01; req_a0 = 64'd1; req_b0 = 64'd2; req_sel0 = 3'b000; req_sub_sra0 = 1'b0;
    @(negedge clk);
    resp_ready = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (resp_valid !== 2'b10 || req_ready !== 2'b00) begin n_fail++; $display("FAIL nonowner_hold[%0d]: got valid %b ready %b expected 10/00", k, resp_valid, req_ready); end
      n_checks++; if (resp_result !== 64'd42 || resp_flags !== 5'b10000) begin n_fail++; $display("FAIL nonowner_data[%0d]: got %0d/%b expected 42/10000", k, resp_result, resp_flags); end
      @(negedge clk);
    end
    $display("txn nonowner: req1 50-8 -> %0d flags %b", resp_result, resp_flags);
    resp_ready = 2'b10;
    @(negedge clk); resp_ready = 2'b00; #1;
    n_checks++; if (req_ready !== 2'b01 || resp_valid !== 2'b00) begin n_fail++; $display("FAIL nonowner_release: got ready %b valid %b expected 01/00", req_ready, resp_valid); end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); resp_ready = 2'b01;
    @(negedge clk); resp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_operand_hold();
    test_reset_midflight();
    test_nonowner_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance between two requesters, e.g. the EXU and the branch/CSR helper.
- Each requester uses an independent valid/ready request channel and response channel.
- Arbitration is round-robin. Accepted operands are registered and driven to the ALU for one evaluation cycle. Result and flags are captured and held until the owning requester accepts them.
- Sits between the pipeline stages and the ALU; the ALU itself stays outside this block.

Parameters:
- XLEN, 64, operand/result width; must match the ALU instance.
- SELW, 3, ALU function-select width.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- req_valid  input  2  per-requester request valid, bit i = requester i
- req_ready  output  2  per-requester request accept
- req_sel0 / req_sel1  input  SELW  ALU function select
- req_a0 / req_a1  input  XLEN  operand a
- req_b0 / req_b1  input  XLEN  operand b
- req_sub_sra0 / req_sub_sra1  input  1  sub/sra modifier
- resp_valid  output  2  per-requester response valid
- resp_ready  input  2  per-requester response accept
- resp_result  output  XLEN  captured ALU result (shared bus, qualified by resp_valid)
- resp_flags  output  5  {cout, zero, overflow, smaller, equal}, captured
- alu_sel  output  SELW  to ALU
- alu_a, alu_b  output  XLEN  to ALU
- alu_sub_sra  output  1  to ALU
- alu_result  input  XLEN  from ALU
- alu_flags  input  5  from ALU, same order as resp_flags

Behaviour:
- FSM states: IDLE, EXEC, RESP. On reset: state IDLE, owner=0, rr_ptr=0 (requester 0 preferred), operand/result/flag registers 0, resp_valid=0, req_ready=0.
- Grant (IDLE only, combinational):
  - If exactly one req_valid bit is set, grant that requester.
  - If both are set, grant requester rr_ptr.
  - If none, no grant.
- req_ready[i] = (state==IDLE) & grant[i]. At most one bit is set. A request must not depend on req_ready.
- IDLE: on a handshake, latch sel/a/b/sub_sra from the granted requester, set owner=i, set rr_ptr=~i, then go to EXEC.
- EXEC: takes exactly one cycle. alu_* outputs are driven from the operand registers (alu_* hold the last operands in all states). At the clock edge, capture alu_result and alu_flags, then go to RESP.
- RESP:
  - resp_valid[owner]=1; the other bit is 0.
  - result and flags hold stable until resp_ready[owner]=1, then go to IDLE.
  - resp_ready of the non-owner is ignored.
- No new request is accepted in the cycle a response handshakes.
- Latency:
  - Request handshake at edge N; result is visible with resp_valid at cycle N+2.
  - Minimum issue interval is 3 cycles per operation.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- A requester dropping req_valid before its handshake loses nothing; no state is kept for it.
- Operands are registered at accept. Later changes on req_* do not affect the in-flight operation.
- rst asserted in any state: immediately returns to IDLE, clears resp_valid and req_ready, resets rr_ptr to 0, and discards the in-flight result.
- Width: all XLEN paths pass through unmodified; no truncation or extension is done in this block.

Test Plan:
1. Reset, then req_valid=01 with sel=000, a=5, b=3, sub_sra=1 -> req_ready=01 for one cycle. Two cycles later resp_valid=01, resp_result=2, zero=0, equal=0.
2. req_valid=11 held with four back-to-back ops -> grants go 0,1,0,1 (rr_ptr starts at 0). Each response appears only on the granted bit.
3. Response backpressure: resp_ready=0 for 5 cycles after resp_valid -> result/flags stable and req_ready=00 throughout. After resp_ready=1 the FSM returns to IDLE and the next request is accepted one cycle later.
4. Operand change after accept: req_a0 changed from 7 to 9 in the EXEC cycle with sel=100, b=7 -> resp_result=0 and zero=1.
5. rst pulsed in EXEC and again in RESP -> resp_valid=00 immediately; the next request is granted to requester 0 when both are valid.
6. Non-owner resp_ready=1 while owner resp_ready=0 -> response is held; state stays RESP.
